// File: rtl/intr_acknowledge_sequencer_if.sv
// Bus-side signal bundle of the interrupt acknowledge sequencer: the 8259 INTR
// line, the core handshake and the INTA#/LOCK# bus cycle.
interface intr_acknowledge_sequencer_if;
    logic       interrupt_request;
    logic       interrupt_enable;
    logic       instruction_boundary;
    logic       ready;
    logic [7:0] data_bus_in;
    logic       interrupt_acknowledge_n;
    logic       lock_n;
    logic       busy;
    logic       vector_valid;
    logic [7:0] vector;
    logic       timeout;
    logic       vector_accept;

    // Sequencer side: drives INTA#/LOCK# and presents the vector.
    modport master (
        input  interrupt_request, interrupt_enable, instruction_boundary,
        input  ready, data_bus_in, vector_accept,
        output interrupt_acknowledge_n, lock_n, busy, vector_valid, vector, timeout
    );

    // Environment side: core, 8259 and system bus.
    modport slave (
        output interrupt_request, interrupt_enable, instruction_boundary,
        output ready, data_bus_in, vector_accept,
        input  interrupt_acknowledge_n, lock_n, busy, vector_valid, vector, timeout
    );
endinterface

// File: rtl/intr_acknowledge_sequencer.sv
// 8088-style two-pulse INTA# sequencer with LOCK#, ready stretching with a
// timeout abort, and a valid/accept handoff of the captured vector.
module intr_acknowledge_sequencer #(
    parameter int unsigned PULSE_CYCLES   = 2,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                          clock,
    input  logic                          reset,
    intr_acknowledge_sequencer_if.master  bus
);
    typedef enum logic [2:0] {IDLE, INTA1, GAP, INTA2, VECTOR} state_t;

    localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);
    localparam logic [7:0] STRETCH_MAX = 8'(TIMEOUT_CYCLES);

    state_t     state_q;
    logic [3:0] pulse_count_q;
    logic [7:0] stretch_count_q;
    logic       inta_n_q;
    logic       lock_n_q;
    logic       busy_q;
    logic       valid_q;
    logic       timeout_q;
    logic [7:0] vector_q;

    logic take;
    logic pulse_min;

    assign take      = bus.interrupt_request & bus.interrupt_enable & bus.instruction_boundary;
    assign pulse_min = (pulse_count_q >= PULSE_LAST);

    // Sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            pulse_count_q   <= '0;
            stretch_count_q <= '0;
            inta_n_q        <= 1'b1;
            lock_n_q        <= 1'b1;
            busy_q          <= 1'b0;
            valid_q         <= 1'b0;
            timeout_q       <= 1'b0;
            vector_q        <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take) begin
                        state_q         <= INTA1;
                        pulse_count_q   <= '0;
                        stretch_count_q <= '0;
                        inta_n_q        <= 1'b0;
                        lock_n_q        <= 1'b0;
                        busy_q          <= 1'b1;
                    end
                end
                INTA1, INTA2: begin
                    if (pulse_min && bus.ready) begin
                        // Normal end of pulse; the second one also captures the vector.
                        pulse_count_q   <= '0;
                        stretch_count_q <= '0;
                        inta_n_q        <= 1'b1;
                        if (state_q == INTA1) begin
                            state_q <= GAP;
                        end else begin
                            state_q   <= VECTOR;
                            lock_n_q  <= 1'b1;
                            valid_q   <= 1'b1;
                            vector_q  <= bus.data_bus_in;
                            timeout_q <= 1'b0;
                        end
                    end else if (pulse_min) begin
                        // Ready low past the minimum: stretch, abort once the budget is spent.
                        if (stretch_count_q == STRETCH_MAX) begin
                            state_q         <= VECTOR;
                            pulse_count_q   <= '0;
                            stretch_count_q <= '0;
                            inta_n_q        <= 1'b1;
                            lock_n_q        <= 1'b1;
                            valid_q         <= 1'b1;
                            vector_q        <= 8'hFF;
                            timeout_q       <= 1'b1;
                        end else begin
                            stretch_count_q <= stretch_count_q + 8'd1;
                        end
                    end else begin
                        pulse_count_q <= pulse_count_q + 4'd1;
                    end
                end
                GAP: begin
                    if (pulse_count_q == GAP_LAST) begin
                        state_q         <= INTA2;
                        pulse_count_q   <= '0;
                        stretch_count_q <= '0;
                        inta_n_q        <= 1'b0;
                    end else begin
                        pulse_count_q <= pulse_count_q + 4'd1;
                    end
                end
                VECTOR: begin
                    if (bus.vector_accept) begin
                        state_q         <= IDLE;
                        pulse_count_q   <= '0;
                        stretch_count_q <= '0;
                        busy_q          <= 1'b0;
                        valid_q         <= 1'b0;
                        timeout_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q         <= IDLE;
                    pulse_count_q   <= '0;
                    stretch_count_q <= '0;
                    inta_n_q        <= 1'b1;
                    lock_n_q        <= 1'b1;
                    busy_q          <= 1'b0;
                    valid_q         <= 1'b0;
                    timeout_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.interrupt_acknowledge_n = inta_n_q;
    assign bus.lock_n                  = lock_n_q;
    assign bus.busy                    = busy_q;
    assign bus.vector_valid            = valid_q;
    assign bus.vector                  = vector_q;
    assign bus.timeout                 = timeout_q;
endmodule

// File: tb/tb_intr_acknowledge_sequencer.sv
// Scenario bench for the interrupt acknowledge sequencer. Expected vectors
// ({timeout, vector}) are queued when the take is driven and popped when
// vector_valid appears. Inputs change 1ns after the rising edge; outputs are
// checked at that point, so "cycle k" means the state after the k-th edge.
module tb_intr_acknowledge_sequencer;
    logic clock;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [8:0] exp_q[$];

    intr_acknowledge_sequencer_if ifc();

    intr_acknowledge_sequencer #(
        .PULSE_CYCLES(2), .GAP_CYCLES(2), .TIMEOUT_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (ifc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (ifc.interrupt_acknowledge_n !== 1'b1) begin n_err++; $display("FAIL reset_inta got %b want 1", ifc.interrupt_acknowledge_n); end
        n_cmp++; if (ifc.lock_n !== 1'b1) begin n_err++; $display("FAIL reset_lock got %b want 1", ifc.lock_n); end
        n_cmp++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", ifc.busy); end
        n_cmp++; if (ifc.vector_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", ifc.vector_valid); end
        n_cmp++; if (ifc.vector !== 8'h00) begin n_err++; $display("FAIL reset_vector got %h want 00", ifc.vector); end
        n_cmp++; if (ifc.timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout got %b want 0", ifc.timeout); end
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [8:0] e;
        logic exp_inta, exp_lock, exp_valid, exp_busy;
        ifc.interrupt_request = 1; ifc.interrupt_enable = 1;
        ifc.instruction_boundary = 1; ifc.data_bus_in = 8'h08;
        exp_q.push_back({1'b0, 8'h08});
        for (int k = 1; k <= 10; k++) begin
            tick();
            ifc.instruction_boundary = 0;
            exp_inta  = !((k >= 1 && k <= 2) || (k >= 5 && k <= 6));
            exp_lock  = !(k >= 1 && k <= 6);
            exp_valid = (k >= 7 && k <= 9);
            exp_busy  = (k <= 9);
            n_cmp++; if (ifc.interrupt_acknowledge_n !== exp_inta) begin n_err++; $display("FAIL basic_inta k=%0d got %b want %b", k, ifc.interrupt_acknowledge_n, exp_inta); end
            n_cmp++; if (ifc.lock_n !== exp_lock) begin n_err++; $display("FAIL basic_lock k=%0d got %b want %b", k, ifc.lock_n, exp_lock); end
            n_cmp++; if (ifc.vector_valid !== exp_valid) begin n_err++; $display("FAIL basic_valid k=%0d got %b want %b", k, ifc.vector_valid, exp_valid); end
            n_cmp++; if (ifc.busy !== exp_busy) begin n_err++; $display("FAIL basic_busy k=%0d got %b want %b", k, ifc.busy, exp_busy); end
            if (k == 7) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL basic_vec scoreboard empty"); end
                else begin
                    e = exp_q.pop_front();
                    if ({ifc.timeout, ifc.vector} !== e) begin n_err++; $display("FAIL basic_vec got %h want %h", {ifc.timeout, ifc.vector}, e); end
                end
            end
            ifc.vector_accept = (k == 9);
        end
        ifc.interrupt_request = 0; ifc.interrupt_enable = 0;
    endtask

    task automatic test_masked();
        ifc.interrupt_request = 1; ifc.interrupt_enable = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) ifc.interrupt_enable = 1;
            ifc.instruction_boundary = (k < 4) ? k[0] : 1'b0;
            tick();
            n_cmp++; if (ifc.interrupt_acknowledge_n !== 1'b1) begin n_err++; $display("FAIL masked_inta k=%0d got %b want 1", k, ifc.interrupt_acknowledge_n); end
            n_cmp++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL masked_busy k=%0d got %b want 0", k, ifc.busy); end
        end
        ifc.instruction_boundary = 0; ifc.interrupt_request = 0; ifc.interrupt_enable = 0;
    endtask

    task automatic test_wait_states();
        logic [8:0] e;
        int low2 = 0;
        int kv = 0;
        ifc.interrupt_request = 1; ifc.interrupt_enable = 1;
        ifc.instruction_boundary = 1; ifc.data_bus_in = 8'h55;
        exp_q.push_back({1'b0, 8'h0D});
        for (int k = 1; k <= 30; k++) begin
            tick();
            ifc.instruction_boundary = 0;
            if (k >= 5 && ifc.interrupt_acknowledge_n === 1'b0) low2++;
            if (ifc.vector_valid === 1'b1) begin kv = k; break; end
            ifc.ready       = !(k >= 5 && k <= 8);
            ifc.data_bus_in = (k >= 9) ? 8'h0D : 8'h55;
        end
        ifc.ready = 1; ifc.interrupt_request = 0; ifc.interrupt_enable = 0;
        n_cmp++; if (kv != 10) begin n_err++; $display("FAIL ws_valid_cycle got %0d want 10", kv); end
        n_cmp++; if (low2 != 5) begin n_err++; $display("FAIL ws_inta2_len got %0d want 5", low2); end
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL ws_vec scoreboard empty"); end
        else begin
            e = exp_q.pop_front();
            if ({ifc.timeout, ifc.vector} !== e) begin n_err++; $display("FAIL ws_vec got %h want %h", {ifc.timeout, ifc.vector}, e); end
        end
        ifc.vector_accept = 1; tick(); ifc.vector_accept = 0;
        n_cmp++; if (ifc.busy !== 1'b0 || ifc.vector_valid !== 1'b0) begin n_err++; $display("FAIL ws_accept busy=%b valid=%b want 0 0", ifc.busy, ifc.vector_valid); end
    endtask

    task automatic test_timeout();
        logic [8:0] e;
        int low = 0;
        int kv = 0;
        ifc.interrupt_request = 1; ifc.interrupt_enable = 1;
        ifc.instruction_boundary = 1; ifc.data_bus_in = 8'h33; ifc.ready = 0;
        exp_q.push_back({1'b1, 8'hFF});
        for (int k = 1; k <= 30; k++) begin
            tick();
            ifc.instruction_boundary = 0;
            if (ifc.interrupt_acknowledge_n === 1'b0) low++;
            if (ifc.vector_valid === 1'b1) begin kv = k; break; end
        end
        n_cmp++; if (kv != 7) begin n_err++; $display("FAIL to_valid_cycle got %0d want 7", kv); end
        n_cmp++; if (low != 6) begin n_err++; $display("FAIL to_inta_low got %0d want 6", low); end
        n_cmp++; if (ifc.lock_n !== 1'b1) begin n_err++; $display("FAIL to_lock got %b want 1", ifc.lock_n); end
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL to_vec scoreboard empty"); end
        else begin
            e = exp_q.pop_front();
            if ({ifc.timeout, ifc.vector} !== e) begin n_err++; $display("FAIL to_vec got %h want %h", {ifc.timeout, ifc.vector}, e); end
        end
        ifc.ready = 1; ifc.interrupt_request = 0; ifc.interrupt_enable = 0;
        ifc.vector_accept = 1; tick(); ifc.vector_accept = 0;
        n_cmp++; if (ifc.busy !== 1'b0 || ifc.vector_valid !== 1'b0) begin n_err++; $display("FAIL to_accept busy=%b valid=%b want 0 0", ifc.busy, ifc.vector_valid); end
    endtask

    task automatic test_intr_drop();
        logic [8:0] e;
        int kv = 0;
        ifc.interrupt_request = 1; ifc.interrupt_enable = 1;
        ifc.instruction_boundary = 1; ifc.data_bus_in = 8'h0F;
        exp_q.push_back({1'b0, 8'h0F});
        for (int k = 1; k <= 30; k++) begin
            tick();
            ifc.instruction_boundary = 0;
            ifc.interrupt_request    = 0;
            ifc.interrupt_enable     = 0;
            if (ifc.vector_valid === 1'b1) begin kv = k; break; end
        end
        n_cmp++; if (kv != 7) begin n_err++; $display("FAIL drop_valid_cycle got %0d want 7", kv); end
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL drop_vec scoreboard empty"); end
        else begin
            e = exp_q.pop_front();
            if ({ifc.timeout, ifc.vector} !== e) begin n_err++; $display("FAIL drop_vec got %h want %h", {ifc.timeout, ifc.vector}, e); end
        end
        ifc.vector_accept = 1; tick(); ifc.vector_accept = 0;
        n_cmp++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL drop_accept busy got %b want 0", ifc.busy); end
    endtask

    task automatic test_reset_mid_gap();
        ifc.interrupt_request = 1; ifc.interrupt_enable = 1;
        ifc.instruction_boundary = 1; ifc.data_bus_in = 8'hAA;
        for (int k = 1; k <= 3; k++) begin
            tick();
            ifc.instruction_boundary = 0;
            ifc.interrupt_request    = 0;
        end
        n_cmp++; if (ifc.interrupt_acknowledge_n !== 1'b1 || ifc.lock_n !== 1'b0) begin n_err++; $display("FAIL gap_state inta=%b lock=%b want 1 0", ifc.interrupt_acknowledge_n, ifc.lock_n); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (ifc.lock_n !== 1'b1) begin n_err++; $display("FAIL rst_async_lock got %b want 1", ifc.lock_n); end
        n_cmp++; if (ifc.interrupt_acknowledge_n !== 1'b1) begin n_err++; $display("FAIL rst_async_inta got %b want 1", ifc.interrupt_acknowledge_n); end
        n_cmp++; if (ifc.busy !== 1'b0 || ifc.vector_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_busy_valid got %b%b want 00", ifc.busy, ifc.vector_valid); end
        tick();
        reset = 1'b0; ifc.interrupt_enable = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_cmp++; if (ifc.busy !== 1'b0 || ifc.vector_valid !== 1'b0 || ifc.interrupt_acknowledge_n !== 1'b1) begin n_err++; $display("FAIL rst_idle k=%0d busy=%b valid=%b inta=%b want 0 0 1", k, ifc.busy, ifc.vector_valid, ifc.interrupt_acknowledge_n); end
        end
    endtask

    initial begin
        reset = 1'b1;
        ifc.interrupt_request = 0; ifc.interrupt_enable = 0; ifc.instruction_boundary = 0;
        ifc.ready = 1; ifc.data_bus_in = 8'h00; ifc.vector_accept = 0;
        test_reset();
        test_basic();
        test_masked();
        test_wait_states();
        test_timeout();
        test_intr_drop();
        test_reset_mid_gap();
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/intr_acknowledge_sequencer.md
Name: intr_acknowledge_sequencer

Overview:
CPU-side counterpart of the KF8259 interrupt output. The block samples the 8259 interrupt line at instruction boundaries. It runs the two-pulse 8088-style INTA# bus sequence with LOCK#, and captures the vector byte the controller drives during the second pulse. It hands that vector to the core through a valid/accept handshake. It sits in the KFPC-XT bus unit between the core's instruction sequencer and the system data bus.

Parameters:
PULSE_CYCLES, 2, minimum clocks each INTA# pulse is held low (1..15).
GAP_CYCLES, 2, clocks INTA# is held high between the two pulses (1..15).
TIMEOUT_CYCLES, 255, maximum extra clocks a pulse may be stretched by ready low before abort (1..255).

Ports:
clock  in  1  system clock; all state changes on rising edge.
reset  in  1  asynchronous, active-high reset.
interrupt_request  in  1  INTR from KF8259, level, synchronous to clock.
interrupt_enable  in  1  CPU IF flag.
instruction_boundary  in  1  one-clock strobe from core: an interrupt may be taken now.
ready  in  1  bus ready; low stretches the current INTA# pulse.
data_bus_in  in  8  system data bus, sampled in the second pulse.
interrupt_acknowledge_n  out  1  INTA# to KF8259, active low.
lock_n  out  1  bus LOCK#, active low.
busy  out  1  high whenever state is not IDLE.
vector_valid  out  1  captured vector available.
vector  out  8  captured interrupt vector.
timeout  out  1  qualifies vector_valid: sequence aborted by ready timeout.
vector_accept  in  1  core consumes the vector; meaningful only while vector_valid=1.

Behaviour:
- Reset values (async, immediate): state=IDLE, interrupt_acknowledge_n=1, lock_n=1, busy=0, vector_valid=0, vector=8'h00, timeout=0, counters=0.
- All outputs are registered, with no combinational path from input to output.
- States: IDLE, INTA1, GAP, INTA2, VECTOR.
- IDLE:
  - Take condition: interrupt_request & interrupt_enable & instruction_boundary all high in the same clock.
  - On take, move to INTA1 next clock. Otherwise stay.
  - An instruction_boundary strobe without the take condition is ignored.
- INTA1:
  - interrupt_acknowledge_n=0 and lock_n=0.
  - pulse_count counts from 0. The pulse ends at the first clock where pulse_count >= PULSE_CYCLES-1 and ready=1; next state is GAP.
  - While ready=0 after the minimum, stretch_count increments.
  - If stretch_count reaches TIMEOUT_CYCLES, abort: go to VECTOR with vector=8'hFF and timeout=1.
- GAP:
  - interrupt_acknowledge_n=1, lock_n stays 0.
  - Lasts exactly GAP_CYCLES clocks, then INTA2.
- INTA2:
  - Same pulse, stretch and timeout rules as INTA1.
  - data_bus_in is registered into vector on the terminating clock (count satisfied and ready=1).
  - Next state is VECTOR with timeout=0.
  - lock_n returns to 1 together with interrupt_acknowledge_n leaving INTA2.
- VECTOR:
  - vector_valid=1, with vector and timeout stable.
  - On a clock with vector_accept=1, go to IDLE next clock and clear vector_valid. vector holds its last value.
  - instruction_boundary is ignored here.
- INTR dropping after the take condition has no effect: the sequence always completes, and the 8259 supplies its spurious IR7 vector.
- interrupt_enable changes mid-sequence are ignored.
- The counters (pulse_count and stretch_count) are cleared on every state entry.
- Latency with PULSE=2, GAP=2, ready=1:
  - take clock T.
  - INTA1 low in T+1..T+2.
  - Gap in T+3..T+4.
  - INTA2 low in T+5..T+6, vector sampled at the T+6 edge.
  - vector_valid=1 from T+7.
- Reset asserted mid-sequence: immediate return to IDLE, with INTA# and LOCK# deasserted asynchronously and no vector presented.

Test Plan:
- Basic: interrupt_request=1, interrupt_enable=1, boundary strobe at T, data_bus_in=8'h08 during INTA2 -> INTA# low T+1..T+2 and T+5..T+6, lock_n low T+1..T+6, vector_valid at T+7 with vector=8'h08, timeout=0; vector_accept at T+9 -> IDLE and busy=0 at T+10.
- Masked/no boundary: interrupt_request=1, interrupt_enable=0 with strobes; then interrupt_enable=1 without a strobe -> INTA# stays 1, busy=0 throughout.
- Wait states: ready=0 for 3 extra clocks in INTA2, data changes from 8'h55 to 8'h0D on the final clock -> INTA2 lasts 5 clocks, vector=8'h0D.
- Timeout: TIMEOUT_CYCLES=4, ready held 0 in INTA1 -> abort after 2+4 clocks low, GAP and INTA2 skipped, vector=8'hFF, timeout=1, lock_n=1.
- INTR drop: interrupt_request falls the clock after the take, bus drives 8'h0F -> full sequence completes, vector=8'h0F.
- Reset mid-GAP: assert reset during GAP -> interrupt_acknowledge_n=1 and lock_n=1 immediately, vector_valid=0; after release with no request -> stays IDLE.
